// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between two byte requesters.
// Drives the baud generator enable and shifts start/data/stop bits on its mid-bit strobes.
module uart_tx_arbiter #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    input  logic              i_clk_bps,
    output logic              o_bps_start,
    output logic              o_rs232_tx,
    output logic              o_busy,
    output logic              o_grant_id
);

    // state | meaning
    // IDLE  | line high, baud generator off, accepting one request
    // SEND  | frame in progress, one bit per clk_bps strobe
    typedef enum logic {IDLE, SEND} state_t;

    localparam int FRAME_W = 1 + DATA_W + STOP_BITS;
    localparam int CNT_W   = $clog2(DATA_W + STOP_BITS + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_last_grant;
    logic                 r_tx;
    logic                 r_bps_start;
    logic                 r_busy;
    logic                 r_grant_id;

    logic                 w_sel;
    logic                 w_xfer;
    logic [DATA_W-1:0]    w_data;

    // On a tie the requester not served last wins.
    assign w_sel        = (i_req0_valid && i_req1_valid) ? ~r_last_grant : i_req1_valid;
    assign o_req0_ready = (r_state == IDLE) && i_req0_valid && !w_sel;
    assign o_req1_ready = (r_state == IDLE) && i_req1_valid && w_sel;
    assign w_xfer       = o_req0_ready || o_req1_ready;
    assign w_data       = w_sel ? i_req1_data : i_req0_data;

    assign o_rs232_tx   = r_tx;
    assign o_bps_start  = r_bps_start;
    assign o_busy       = r_busy;
    assign o_grant_id   = r_grant_id;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_tx         <= 1'b1;
            r_bps_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_grant_id   <= 1'b0;
            r_bit_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_shift      <= '1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_shift      <= {{STOP_BITS{1'b1}}, w_data, 1'b0};
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                        r_bit_cnt    <= '0;
                        r_bps_start  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (i_clk_bps) begin
                        if (r_bit_cnt < LAST_CNT) begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b1, r_shift[FRAME_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
                            // Strobe at the end of the last stop bit closes the frame.
                            r_tx        <= 1'b1;
                            r_bps_start <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
